// File: rtl/uart_packetizer.sv
// uart_packetizer: frames one NUM_BYTES payload word as HEADER, payload bytes
// (MSB first) and an XOR checksum, offered one byte at a time over a
// valid/ready handshake to a UART transmitter. All outputs are registered.
module uart_packetizer #(
    parameter int          NUM_BYTES = 4,
    parameter logic [7:0]  HEADER    = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_BYTES*8-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_PAY  = 2'd2,
        S_CHK  = 2'd3
    } state_t;

    state_t                   state_q;
    logic [IW-1:0]            idx_q;
    logic [7:0]               csum_q;
    logic [NUM_BYTES*8-1:0]   payload_q;
    logic [7:0]               out_data_q;
    logic                     out_valid_q;
    logic                     in_ready_q;
    logic                     busy_q;

    logic [IW-1:0]            idx_d;
    logic [7:0]               csum_d;
    logic [7:0]               next_byte_d;

    // Byte view of the captured payload so a byte can be picked by index.
    logic [7:0] pay_bytes [NUM_BYTES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi = gi + 1) begin : g_bytes
            assign pay_bytes[gi] = payload_q[gi*8 +: 8];
        end
    endgenerate

    // Next index, running checksum including the byte being accepted, and
    // the payload byte that follows the current one.
    always_comb begin
        idx_d       = idx_q - IW'(1);
        csum_d      = csum_q ^ out_data_q;
        next_byte_d = pay_bytes[idx_d];
    end

    // Packet FSM; every output is loaded together with the state it belongs to,
    // so the next byte is already on out_data the cycle after an acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            csum_q      <= '0;
            payload_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        payload_q   <= in_data;
                        csum_q      <= '0;
                        idx_q       <= '0;
                        out_data_q  <= HEADER;
                        out_valid_q <= 1'b1;
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (out_ready) begin
                        idx_q      <= IDX_TOP;
                        out_data_q <= pay_bytes[IDX_TOP];
                        state_q    <= S_PAY;
                    end
                end
                S_PAY: begin
                    if (out_ready) begin
                        csum_q <= csum_d;
                        if (idx_q == '0) begin
                            out_data_q <= csum_d;
                            state_q    <= S_CHK;
                        end else begin
                            idx_q      <= idx_d;
                            out_data_q <= next_byte_d;
                        end
                    end
                end
                S_CHK: begin
                    if (out_ready) begin
                        out_data_q  <= '0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    idx_q       <= '0;
                    csum_q      <= '0;
                    out_data_q  <= '0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_packetizer.sv
// Testbench for uart_packetizer (NUM_BYTES=4, HEADER=A5): directed vector table,
// hand sequences for backpressure, held input and reset, plus random payloads
// and random backpressure checked against a packet model.
module tb_uart_packetizer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    uart_packetizer #(.NUM_BYTES(4), .HEADER(8'hA5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [47:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference packet: header, payload bytes MSB first, XOR of payload bytes.
    function automatic logic [47:0] model_pkt(input logic [31:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 4; i++) c = c ^ d[8*i +: 8];
        return {8'hA5, d, c};
    endfunction

    // Capture one payload and collect its 6 bytes. Inputs are driven and
    // outputs sampled on the falling edge.
    task automatic run_packet(input logic [31:0] d, input int stall_pct,
                              input int stall_hdr, input int stall_b2,
                              input bit hold_next, input logic [31:0] next_d,
                              output logic [47:0] got);
        int budget;
        int n;
        int s0;
        int s2;
        bit held;
        logic [7:0] prev;
        got    = '0;
        budget = 0;
        while (in_ready !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        if (hold_next) begin
            in_data = next_d;
        end else begin
            in_valid = 1'b0;
            in_data  = $urandom;
        end
        n = 0; s0 = 0; s2 = 0; held = 1'b0; prev = 8'h00; budget = 0;
        while (n < 6 && budget < 300) begin
            chk("out_valid_in_packet", {63'd0, out_valid}, 64'd1);
            if (out_valid !== 1'b1) break;
            chk("in_ready_busy_in_packet", {62'd0, in_ready, busy}, 64'd1);
            if (held) chk("out_data_stable", {56'd0, out_data}, {56'd0, prev});
            if (n == 0 && s0 < stall_hdr) begin
                out_ready = 1'b0;
                s0++;
            end else if (n == 2 && s2 < stall_b2) begin
                out_ready = 1'b0;
                s2++;
            end else begin
                out_ready = ($urandom_range(99) >= stall_pct);
            end
            held = !out_ready;
            prev = out_data;
            if (out_ready) begin
                got[47 - 8*n -: 8] = out_data;
                n++;
            end
            @(negedge clk);
            budget++;
        end
        out_ready = 1'b0;
        chk("packet_length", 64'(n), 64'd6);
        chk("idle_after_chk", {61'd0, out_valid, busy, in_ready}, 64'd1);
    endtask

    logic [47:0] got;

    initial begin
        vecs[0] = '{32'h12345678, 48'hA5_12345678_08};
        vecs[1] = '{32'h00000000, 48'hA5_00000000_00};
        vecs[2] = '{32'hDEADBEEF, 48'hA5_DEADBEEF_22};
        vecs[3] = '{32'hFFFFFFFF, 48'hA5_FFFFFFFF_00};
        vecs[4] = '{32'h01020408, 48'hA5_01020408_0F};
        vecs[5] = '{32'h80000001, 48'hA5_80000001_81};

        rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", {52'd0, in_ready, out_valid, busy, 1'b0, out_data},
            {52'd0, 4'b1000, 8'h00});
        rst = 1'b0;
        @(negedge clk);

        // Directed table, no backpressure.
        for (int i = 0; i < 6; i++) begin
            run_packet(vecs[i].data, 0, 0, 0, 1'b0, 32'h0, got);
            chk($sformatf("table_%0d", i), {16'd0, got}, {16'd0, vecs[i].exp});
            $display("table %0d data=%h got=%h", i, vecs[i].data, got);
        end

        // Backpressure: 10 stall cycles on the header, 5 on byte 34.
        run_packet(32'h12345678, 0, 10, 5, 1'b0, 32'h0, got);
        chk("backpressure_stream", {16'd0, got}, {16'd0, 48'hA5_12345678_08});
        $display("backpressure got=%h", got);

        // Input held valid during a packet: the new word waits for the next IDLE.
        run_packet(32'h12345678, 0, 0, 0, 1'b1, 32'hDEADBEEF, got);
        chk("held_first", {16'd0, got}, {16'd0, 48'hA5_12345678_08});
        run_packet(32'hDEADBEEF, 0, 0, 0, 1'b0, 32'h0, got);
        chk("held_second", {16'd0, got}, {16'd0, 48'hA5_DEADBEEF_22});
        $display("held second got=%h", got);

        // Reset after byte 34 accepted, with handshakes active on both sides.
        in_data = 32'h12345678; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);   // A5 accepted
        @(negedge clk);   // 12 accepted
        @(negedge clk);   // 34 accepted
        chk("pre_reset_byte", {56'd0, out_data}, {56'd0, 8'h56});
        rst = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("reset_abort", {52'd0, in_ready, out_valid, busy, 1'b0, out_data},
            {52'd0, 4'b1000, 8'h00});
        @(negedge clk);
        chk("reset_stays_idle", {61'd0, out_valid, busy, in_ready}, 64'd1);
        // Reset coinciding with a capture request in IDLE: no capture.
        rst = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        chk("reset_beats_capture", {61'd0, out_valid, busy, in_ready}, 64'd1);
        run_packet(32'h12345678, 0, 0, 0, 1'b0, 32'h0, got);
        chk("after_reset_stream", {16'd0, got}, {16'd0, 48'hA5_12345678_08});
        $display("after reset got=%h", got);

        // Random payloads with random backpressure.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] d;
            int pct;
            d   = $urandom;
            pct = int'($urandom_range(70));
            run_packet(d, pct, 0, 0, 1'b0, 32'h0, got);
            chk($sformatf("random_%0d", i), {16'd0, got}, {16'd0, model_pkt(d)});
            $display("random %0d data=%h stall=%0d got=%h", i, d, pct, got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
